// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: APU frame counter producing quarter/half-frame clocks and the frame IRQ.
// Programmed by $4017 writes; a write restarts the sequence after a short delay.
module apu_frame_sequencer #(
  parameter int STEP1    = 7457,
  parameter int STEP2    = 14913,
  parameter int STEP3    = 22371,
  parameter int STEP4    = 29829,
  parameter int STEP5    = 37281,
  parameter int CNT_W    = 16,
  parameter int WR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_clear,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq
);
  localparam int DW = $clog2(WR_DELAY + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0]    r_dly, w_dly_nxt;
  logic r_mode, r_inhibit, r_irq, r_qf, r_hf;
  logic w_s1, w_s2, w_s3, w_s4, w_s5, w_end, w_expire, w_qf, w_hf, w_irq_nxt;
  logic w_unused;
  assign w_unused = &{1'b0, wr_data[5:0]};
  always_comb begin
    w_s1 = r_cnt == CNT_W'(STEP1);
    w_s2 = r_cnt == CNT_W'(STEP2);
    w_s3 = r_cnt == CNT_W'(STEP3);
    w_s4 = r_cnt == CNT_W'(STEP4);
    w_s5 = r_cnt == CNT_W'(STEP5);
    // a fresh write restarts the delay, so it overrides an expiry on the same edge
    w_expire  = (r_dly == DW'(1)) && !wr_en;
    w_end     = r_mode ? w_s5 : w_s4;
    w_qf      = w_expire ? r_mode : (w_s1 | w_s2 | w_s3 | w_end);
    w_hf      = w_expire ? r_mode : (w_s2 | w_end);
    w_cnt_nxt = (w_expire || w_end) ? '0 : r_cnt + 1'b1;
    w_dly_nxt = wr_en ? DW'(WR_DELAY) : (r_dly != '0) ? r_dly - DW'(1) : r_dly;
    w_irq_nxt = (wr_en && wr_data[6]) ? 1'b0 :
                (!w_expire && !r_mode && w_s4 && !r_inhibit) ? 1'b1 :
                irq_clear ? 1'b0 : r_irq;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_dly     <= '0;
      r_mode    <= 1'b0;
      r_inhibit <= 1'b0;
      r_irq     <= 1'b0;
      r_qf      <= 1'b0;
      r_hf      <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_dly     <= w_dly_nxt;
      r_irq     <= w_irq_nxt;
      r_qf      <= w_qf;
      r_hf      <= w_hf;
      if (wr_en) begin
        r_mode    <= wr_data[7];
        r_inhibit <= wr_data[6];
      end
    end
  end
  assign quarter_frame = r_qf;
  assign half_frame    = r_hf;
  assign frame_irq     = r_irq;
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: scoreboard bench; expected pulse edges are queued from the
// known sequence timeline and matched against observed pulses after each scenario.
module tb_apu_frame_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, irq_clear = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic quarter_frame, half_frame, frame_irq;
  typedef struct packed { logic [15:0] e; logic q; logic h; } ev_t;
  ev_t exp_q[$], obs_q[$];
  int e = 0, errors = 0, checks = 0;
  logic irq_seen = 1'b0;

  apu_frame_sequencer #(.STEP1(10), .STEP2(20), .STEP3(30), .STEP4(40), .STEP5(50),
    .CNT_W(16), .WR_DELAY(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .irq_clear(irq_clear),
    .quarter_frame(quarter_frame), .half_frame(half_frame), .frame_irq(frame_irq));

  always #5 clk = ~clk;

  task automatic push_ev(input int t, input logic q, input logic h);
    ev_t v;
    v.e = 16'(t); v.q = q; v.h = h;
    exp_q.push_back(v);
  endtask

  task automatic push4(input int b);
    push_ev(b + 11, 1, 0); push_ev(b + 21, 1, 1); push_ev(b + 31, 1, 0); push_ev(b + 41, 1, 1);
  endtask

  task automatic push5(input int b);
    push_ev(b + 11, 1, 0); push_ev(b + 21, 1, 1); push_ev(b + 31, 1, 0); push_ev(b + 51, 1, 1);
  endtask

  // inputs drive the next edge; edge numbers count from reset release (edge 1 samples cnt=0)
  task automatic cyc(input logic we, input logic [7:0] wd, input logic ic);
    ev_t v;
    wr_en = we; wr_data = wd; irq_clear = ic;
    @(posedge clk); #1;
    e++;
    if (quarter_frame || half_frame) begin
      v.e = 16'(e); v.q = quarter_frame; v.h = half_frame;
      obs_q.push_back(v);
    end
    if (frame_irq) irq_seen = 1'b1;
    wr_en = 1'b0; irq_clear = 1'b0; wr_data = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; irq_clear = 1'b0; wr_data = 8'h00;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    e = 0; irq_seen = 1'b0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (quarter_frame !== 1'b0) begin errors++; $display("FAIL reset_qf: got %b want 0", quarter_frame); end
    checks++; if (half_frame !== 1'b0) begin errors++; $display("FAIL reset_hf: got %b want 0", half_frame); end
    checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", frame_irq); end
  endtask

  task automatic test_four_step();
    ev_t x, o;
    do_reset();
    push4(0); push4(41);
    for (int i = 1; i <= 90; i++) begin
      cyc(0, 8'h00, 0);
      if (i == 40) begin checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL four_irq_early: got %b want 0", frame_irq); end end
      if (i == 41) begin checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL four_irq_set: got %b want 1", frame_irq); end end
    end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL four_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL four_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  task automatic test_irq_clear();
    ev_t x, o;
    do_reset();
    push4(0); push4(41);
    for (int i = 1; i <= 82; i++) begin
      cyc(0, 8'h00, (i == 42 || i == 82));
      if (i == 41) begin checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL clr_pre: got %b want 1", frame_irq); end end
      if (i == 42) begin checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL clr_clear: got %b want 0", frame_irq); end end
      if (i == 81) begin checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL clr_hold: got %b want 0", frame_irq); end end
      if (i == 82) begin checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b want 1", frame_irq); end end
    end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL clr_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL clr_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  task automatic test_five_step();
    ev_t x, o;
    do_reset();
    push_ev(9, 1, 1); push5(9); push5(60); push5(111);
    push_ev(173, 1, 0); push_ev(183, 1, 1); push_ev(193, 1, 0);
    for (int i = 1; i <= 210; i++) cyc(i == 6, 8'h80, 0);
    checks++; if (irq_seen !== 1'b0) begin errors++; $display("FAIL five_irq: got %b want 0", irq_seen); end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL five_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL five_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  task automatic test_inhibit();
    ev_t x, o;
    do_reset();
    push4(0); push4(45); push4(86);
    for (int i = 1; i <= 130; i++) begin
      cyc(i == 42, 8'h40, 0);
      if (i == 41) begin checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL inh_pre: got %b want 1", frame_irq); end end
      if (i == 42) begin
        checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL inh_clear: got %b want 0", frame_irq); end
        irq_seen = 1'b0;
      end
    end
    checks++; if (irq_seen !== 1'b0) begin errors++; $display("FAIL inh_hold: got %b want 0", irq_seen); end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL inh_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL inh_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  task automatic test_back_to_back();
    ev_t x, o;
    do_reset();
    push_ev(11, 1, 0); push4(14);
    for (int i = 1; i <= 60; i++) cyc(i == 9 || i == 11, 8'h00, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL b2b_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  task automatic test_expiry_suppress();
    ev_t x, o;
    do_reset();
    push4(11);
    for (int i = 1; i <= 60; i++) cyc(i == 8, 8'h00, 0);
    do_reset();
    push_ev(11, 1, 0); push_ev(21, 1, 1); push_ev(31, 1, 0); push4(41);
    for (int i = 1; i <= 82; i++) begin
      cyc(i == 38, 8'h00, 0);
      if (i == 81) begin checks++; if (irq_seen !== 1'b0) begin errors++; $display("FAIL sup_irq: got %b want 0", irq_seen); end end
      if (i == 82) begin checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL sup_irq_next: got %b want 1", frame_irq); end end
    end
    // the first run's events were discarded by do_reset, so rerun it checking pulses only
    do_reset();
    push4(11);
    push_ev(11 + 41 + 11, 1, 0); push_ev(11 + 41 + 21, 1, 1);
    for (int i = 1; i <= 75; i++) cyc(i == 8, 8'h00, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL sup_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL sup_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  task automatic test_async_reset();
    ev_t x, o;
    do_reset();
    push4(0); push_ev(52, 1, 0); push_ev(62, 1, 1);
    for (int i = 1; i <= 65; i++) cyc(i == 64, 8'h00, 0);
    checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL ares_pre: got %b want 1", frame_irq); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL ares_irq: got %b want 0", frame_irq); end
    checks++; if (quarter_frame !== 1'b0 || half_frame !== 1'b0) begin errors++; $display("FAIL ares_pulse: got %b%b want 00", quarter_frame, half_frame); end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL ares_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    do_reset();
    push4(0);
    for (int i = 1; i <= 45; i++) cyc(0, 8'h00, 0);
    checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL ares_post_irq: got %b want 1", frame_irq); end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
      checks++;
      if (o !== x) begin errors++; $display("FAIL ares_post_evt: got e=%0d q=%b h=%b want e=%0d q=%b h=%b", o.e, o.q, o.h, x.e, x.q, x.h); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL ares_extra: got %0d extra pulses first e=%0d want 0", obs_q.size(), obs_q[0].e); end
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_irq_clear();
    test_five_step();
    test_inhibit();
    test_back_to_back();
    test_expiry_suppress();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
